gsim_mat_mem_resp: RTL and testbench

- Responder end of the matrix-memory read interface that the GSIM solver initiates: o_mem_rreq/o_mem_addr in, i_mem_rrdy/i_mem_dout/i_mem_dout_vld out.
- Sits between the solver and a single-port matrix SRAM macro.
- Accepts read requests, issues SRAM reads and returns 256-bit rows after a fixed latency.
- Injects deterministic ready stalls that model bank-refresh gaps.
- A host load port fills the SRAM before processing.

---
 rtl/gsim_pkg.sv | 15 +
 rtl/gsim_vld_pipe.sv | 40 ++++
 rtl/gsim_mat_mem_resp.sv | 133 +++++++++++++
 tb/tb_gsim_mat_mem_resp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared types and constants for the GSIM matrix-memory responder.
package gsim_pkg;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 256;
  localparam int MAT_ROWS = 17;
  localparam int MAT_MAX  = 32;

  typedef enum logic {S_READY = 1'b0, S_BUSY = 1'b1} state_e;

  // Tag carried alongside each accepted read while the SRAM answers
  typedef struct packed {
    logic vld;
    logic oor;
  } rd_tag_t;
endpackage

// File: rtl/gsim_vld_pipe.sv
// Delay line for read data plus valid; only the valids see reset.
module gsim_vld_pipe #(
  parameter int STAGES = 1,
  parameter int W      = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  generate
    if (STAGES == 0) begin : g_thru
      assign o_vld = i_vld;
      assign o_dat = i_dat;
    end else begin : g_pipe
      logic [STAGES:1]        vld_pipe;
      logic [STAGES:1][W-1:0] dat_pipe;

      // Valid shift register; reset drops everything in flight
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_pipe <= '0;
        else begin
          vld_pipe[1] <= i_vld;
          for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
      end

      // Data shift register; contents are qualified by the valids
      always_ff @(posedge i_clk) begin
        dat_pipe[1] <= i_dat;
        for (int s = 2; s <= STAGES; s++) dat_pipe[s] <= dat_pipe[s-1];
      end

      assign o_vld = vld_pipe[STAGES];
      assign o_dat = dat_pipe[STAGES];
    end
  endgenerate
endmodule

// File: rtl/gsim_mat_mem_resp.sv
// Matrix-memory read responder: solver reads, host loads, periodic refresh stalls.
module gsim_mat_mem_resp
  import gsim_pkg::*;
#(
  parameter int ADDR_W      = gsim_pkg::ADDR_W,
  parameter int DATA_W      = gsim_pkg::DATA_W,
  parameter int DEPTH       = gsim_pkg::MAT_ROWS * gsim_pkg::MAT_MAX,
  parameter int LATENCY     = 2,
  parameter int BUSY_PERIOD = 8,
  parameter int BUSY_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rreq,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_rrdy,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_vld,
  input  logic              i_load_wen,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_sram_ren,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic              o_err
);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]  BP      = CNT_W'(BUSY_PERIOD);
  localparam logic [CNT_W-1:0]  BC      = CNT_W'(BUSY_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  acc_q, acc_d, busy_q, busy_d;
  logic              accept, in_range;
  rd_tag_t           tag_q;
  logic [DATA_W-1:0] q_dat, out_dat, hold_q;
  logic              out_vld;

  // Ready is low during reset, stall windows and host load cycles
  assign o_rrdy   = i_rst_n & (state_q == S_READY) & ~i_load_wen;
  assign accept   = i_rreq & o_rrdy;
  assign in_range = {1'b0, i_addr} < DEPTH_L;

  // SRAM port: host load owns it; otherwise an accepted in-range read
  always_comb begin
    o_sram_ren   = 1'b0;
    o_sram_wen   = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (i_rst_n) begin
      if (i_load_wen) begin
        o_sram_wen   = 1'b1;
        o_sram_addr  = i_load_addr;
        o_sram_wdata = i_load_data;
      end else if (accept && in_range) begin
        o_sram_ren  = 1'b1;
        o_sram_addr = i_addr;
      end
    end
  end

  // Stall FSM next-state: count accepts, then hold ready low for the refresh gap
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    case (state_q)
      S_READY: begin
        if (accept && BUSY_PERIOD != 0) begin
          if (acc_q + 1'b1 == BP) begin
            state_d = S_BUSY;
            acc_d   = '0;
            busy_d  = BC;
          end else begin
            acc_d = acc_q + 1'b1;
          end
        end
      end
      S_BUSY: begin
        busy_d = (busy_q != '0) ? busy_q - 1'b1 : '0;
        if (busy_q <= CNT_W'(1)) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // Stall FSM state and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_READY;
      acc_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
    end
  end

  // Tag the accepted read for the cycle SRAM data returns; sticky range error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q <= '0;
      o_err <= 1'b0;
    end else begin
      tag_q <= '{vld: accept, oor: accept & ~in_range};
      if (accept && !in_range) o_err <= 1'b1;
    end
  end

  // Out-of-range reads return zero instead of whatever the SRAM holds
  assign q_dat = tag_q.oor ? '0 : i_sram_q;

  gsim_vld_pipe #(.STAGES(LATENCY-1), .W(DATA_W)) u_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (tag_q.vld),
    .i_dat   (q_dat),
    .o_vld   (out_vld),
    .o_dat   (out_dat)
  );

  // Last returned row, so o_dout holds between pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     hold_q <= '0;
    else if (out_vld) hold_q <= out_dat;
  end

  assign o_dout     = out_vld ? out_dat : hold_q;
  assign o_dout_vld = out_vld;
endmodule

// File: tb/tb_gsim_mat_mem_resp.sv
// Scoreboard bench for gsim_mat_mem_resp: default build plus a LATENCY=1, no-stall build.
module tb_gsim_mat_mem_resp;
  localparam int AW = 10;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rreq, rrdy, dvld, lwen, sren, swen, err;
  logic [AW-1:0] addr, laddr, saddr;
  logic [DW-1:0] dout, ldata, swdata, sq;
  logic          rreq1, rrdy1, dvld1, lwen1, sren1, swen1, err1;
  logic [AW-1:0] addr1, laddr1, saddr1;
  logic [DW-1:0] dout1, ldata1, swdata1, sq1;

  gsim_mat_mem_resp dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_addr(addr), .o_rrdy(rrdy),
    .o_dout(dout), .o_dout_vld(dvld), .i_load_wen(lwen), .i_load_addr(laddr),
    .i_load_data(ldata), .o_sram_ren(sren), .o_sram_wen(swen), .o_sram_addr(saddr),
    .o_sram_wdata(swdata), .i_sram_q(sq), .o_err(err));

  gsim_mat_mem_resp #(.LATENCY(1), .BUSY_PERIOD(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq1), .i_addr(addr1), .o_rrdy(rrdy1),
    .o_dout(dout1), .o_dout_vld(dvld1), .i_load_wen(lwen1), .i_load_addr(laddr1),
    .i_load_data(ldata1), .o_sram_ren(sren1), .o_sram_wen(swen1), .o_sram_addr(saddr1),
    .o_sram_wdata(swdata1), .i_sram_q(sq1), .o_err(err1));

  // SRAM models: q valid one cycle after ren
  logic [DW-1:0] mem  [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  always @(posedge clk) begin
    if (swen) mem[saddr] <= swdata;
    if (sren) sq <= mem[saddr];
  end
  always @(posedge clk) begin
    if (swen1) mem1[saddr1] <= swdata1;
    if (sren1) sq1 <= mem1[saddr1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t sb[$];
  exp_t sb1[$];

  function automatic logic [DW-1:0] row(input int r);
    return {16{r[15:0]}};
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (dvld) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL vld_unexpected: got vld with dout=%h, required no response", dout);
        end else begin
          e = sb.pop_front();
          if (dout !== e.data || cyc != e.due) begin
            n_fail++; $display("FAIL resp: got %h at cyc %0d, required %h at cyc %0d", dout, cyc, e.data, e.due);
          end
        end
      end
    end
  endtask

  task automatic monitor1();
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (dvld1) begin
        n_tests++;
        if (sb1.size() == 0) begin
          n_fail++; $display("FAIL lat1_vld_unexpected: got vld with dout=%h, required no response", dout1);
        end else begin
          e = sb1.pop_front();
          if (dout1 !== e.data || cyc != e.due) begin
            n_fail++; $display("FAIL lat1_resp: got %h at cyc %0d, required %h at cyc %0d", dout1, cyc, e.data, e.due);
          end
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk); rreq = 1'b0; lwen = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0; rreq = 1'b0; lwen = 1'b0; sb.delete();
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Hold a read until accepted (bounded); expected row enters the scoreboard
  task automatic rd(input int a, input logic [DW-1:0] d);
    int t;
    @(negedge clk); rreq = 1'b1; addr = AW'(a); #1;
    t = 0;
    while (!rrdy && t < 20) begin @(negedge clk); #1; t++; end
    n_tests++;
    if (!rrdy) begin n_fail++; $display("FAIL rd_accept addr %0d: got rrdy=0, required 1", a); end
    else sb.push_back('{d, cyc + 2});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rreq = 1'b1; addr = 5; lwen = 1'b1; laddr = 9; ldata = '1;
    @(negedge clk); #1;
    n_tests++; if (rrdy !== 1'b0)   begin n_fail++; $display("FAIL reset_rrdy: got %b, required 0", rrdy); end
    n_tests++; if (dvld !== 1'b0)   begin n_fail++; $display("FAIL reset_vld: got %b, required 0", dvld); end
    n_tests++; if (dout !== '0)     begin n_fail++; $display("FAIL reset_dout: got %h, required 0", dout); end
    n_tests++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    n_tests++; if (sren !== 1'b0)   begin n_fail++; $display("FAIL reset_sram_ren: got %b, required 0", sren); end
    n_tests++; if (swen !== 1'b0)   begin n_fail++; $display("FAIL reset_sram_wen: got %b, required 0", swen); end
    n_tests++; if (saddr !== '0)    begin n_fail++; $display("FAIL reset_sram_addr: got %0d, required 0", saddr); end
    n_tests++; if (swdata !== '0)   begin n_fail++; $display("FAIL reset_sram_wdata: got %h, required 0", swdata); end
    @(negedge clk); rreq = 1'b0; lwen = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (rrdy !== 1'b1)   begin n_fail++; $display("FAIL reset_release_rrdy: got %b, required 1", rrdy); end
  endtask

  task automatic test_load();
    for (int r = 0; r < 17; r++) begin
      @(negedge clk); lwen = 1'b1; laddr = AW'(r); ldata = row(r); #1;
      n_tests++;
      if (swen !== 1'b1 || saddr !== AW'(r) || swdata !== row(r)) begin
        n_fail++; $display("FAIL load_port row %0d: got wen=%b addr=%0d, required wen=1 addr=%0d", r, swen, saddr, r);
      end
    end
    idle();
  endtask

  task automatic test_single();
    rd(5, row(5));
    n_tests++;
    if (sren !== 1'b1 || saddr !== AW'(5)) begin
      n_fail++; $display("FAIL single_sram: got ren=%b addr=%0d, required ren=1 addr=5", sren, saddr);
    end
    idle(); drain();
    @(negedge clk); #1;
    n_tests++;
    if (dvld !== 1'b0 || dout !== row(5)) begin
      n_fail++; $display("FAIL single_hold: got vld=%b dout=%h, required vld=0 dout=%h", dvld, dout, row(5));
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic exp_rdy;
    apply_reset();
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); rreq = 1'b1; addr = AW'(k); #1;
      exp_rdy = (i != 8 && i != 9);
      n_tests++;
      if (rrdy !== exp_rdy) begin n_fail++; $display("FAIL b2b_rrdy cycle %0d: got %b, required %b", i, rrdy, exp_rdy); end
      if (rrdy && k < 10) begin sb.push_back('{row(k), cyc + 2}); k++; end
    end
    n_tests++;
    if (k != 10) begin n_fail++; $display("FAIL b2b_accepts: got %0d, required 10", k); end
    idle(); drain();
  endtask

  task automatic test_load_priority();
    @(negedge clk); lwen = 1'b1; laddr = 3; ldata = {16{16'hAAAA}}; rreq = 1'b1; addr = 3; #1;
    n_tests++; if (rrdy !== 1'b0)  begin n_fail++; $display("FAIL prio_rrdy: got %b, required 0", rrdy); end
    n_tests++; if (swen !== 1'b1)  begin n_fail++; $display("FAIL prio_wen: got %b, required 1", swen); end
    n_tests++; if (sren !== 1'b0)  begin n_fail++; $display("FAIL prio_ren: got %b, required 0", sren); end
    n_tests++; if (saddr !== AW'(3)) begin n_fail++; $display("FAIL prio_addr: got %0d, required 3", saddr); end
    @(negedge clk); lwen = 1'b0; #1;
    n_tests++;
    if (rrdy !== 1'b1) begin n_fail++; $display("FAIL prio_retry_rrdy: got %b, required 1", rrdy); end
    else sb.push_back('{{16{16'hAAAA}}, cyc + 2});
    idle(); drain();
  endtask

  task automatic test_oor();
    rd(600, '0);
    n_tests++; if (sren !== 1'b0) begin n_fail++; $display("FAIL oor_ren: got %b, required 0", sren); end
    idle(); drain();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b, required 1", err); end
    rd(1, row(1)); rd(2, row(2)); idle(); drain();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky: got %b, required 1", err); end
  endtask

  task automatic test_reset_midop();
    rd(7, row(7));
    @(negedge clk); rst_n = 1'b0; rreq = 1'b0; sb.delete(); #1;
    n_tests++; if (dvld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld: got %b, required 0", dvld); end
    n_tests++; if (dout !== '0)   begin n_fail++; $display("FAIL midrst_dout: got %h, required 0", dout); end
    n_tests++; if (rrdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rrdy: got %b, required 0", rrdy); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL midrst_err: got %b, required 0", err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_tests++; if (rrdy !== 1'b1) begin n_fail++; $display("FAIL midrst_release_rrdy: got %b, required 1", rrdy); end
    n_tests++; if (dout !== '0)   begin n_fail++; $display("FAIL midrst_release_dout: got %h, required 0", dout); end
  endtask

  task automatic test_lat1();
    for (int r = 0; r < 544; r++) begin
      @(negedge clk); lwen1 = 1'b1; laddr1 = AW'(r); ldata1 = row(r);
    end
    @(negedge clk); lwen1 = 1'b0;
    for (int a = 0; a < 544; a++) begin
      @(negedge clk); rreq1 = 1'b1; addr1 = AW'(a); #1;
      n_tests++;
      if (rrdy1 !== 1'b1) begin n_fail++; $display("FAIL lat1_rrdy addr %0d: got %b, required 1", a, rrdy1); end
      else sb1.push_back('{row(a), cyc + 1});
    end
    @(negedge clk); rreq1 = 1'b0;
    for (int t = 0; t < 20 && sb1.size() > 0; t++) @(negedge clk);
    n_tests++;
    if (sb1.size() != 0) begin n_fail++; $display("FAIL lat1_drain: got %0d pending, required 0", sb1.size()); end
    n_tests++;
    if (err1 !== 1'b0) begin n_fail++; $display("FAIL lat1_err: got %b, required 0", err1); end
  endtask

  initial begin
    rst_n = 1'b0; rreq = 1'b0; addr = '0; lwen = 1'b0; laddr = '0; ldata = '0;
    rreq1 = 1'b0; addr1 = '0; lwen1 = 1'b0; laddr1 = '0; ldata1 = '0;
    fork
      monitor();
      monitor1();
    join_none
    test_reset();
    test_load();
    test_single();
    test_back_to_back();
    test_load_priority();
    test_oor();
    test_reset_midop();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end
endmodule
